// File: rtl/execute_stage_md.sv
// Execute stage with M-extension: forwarding muxes, ALU with branch compare and JALR target,
// single-cycle multiplier, iterative restoring divider, and the EX/MEM pipeline register.
module execute_stage_md #(
   parameter int XLEN      = 32,
   parameter int REG_AW    = 5,
   parameter int MULDIV_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_FlushE,
   input  logic              i_RegWriteE,
   input  logic              i_MemWriteE,
   input  logic              i_ResultSrcE,
   input  logic              i_ALUSrcE,
   input  logic              i_JumpE,
   input  logic              i_JalrE,
   input  logic              i_BranchE,
   input  logic [2:0]        i_BranchOpE,
   input  logic [3:0]        i_ALUControlE,
   input  logic [XLEN-1:0]   i_RD1_E,
   input  logic [XLEN-1:0]   i_RD2_E,
   input  logic [XLEN-1:0]   i_Imm_Ext_E,
   input  logic [XLEN-1:0]   i_PCE,
   input  logic [XLEN-1:0]   i_PCPlus4E,
   input  logic [XLEN-1:0]   i_ResultW,
   input  logic [REG_AW-1:0] i_RD_E,
   input  logic [1:0]        i_ForwardA_E,
   input  logic [1:0]        i_ForwardB_E,
   output logic              o_PCSrcE,
   output logic [XLEN-1:0]   o_PCTargetE,
   output logic              o_StallE,
   output logic              o_RegWriteM,
   output logic              o_MemWriteM,
   output logic              o_ResultSrcM,
   output logic [REG_AW-1:0] o_RD_M,
   output logic [XLEN-1:0]   o_PCPlus4M,
   output logic [XLEN-1:0]   o_WriteDataM,
   output logic [XLEN-1:0]   o_ALU_ResultM
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } divState_t;

   logic [XLEN-1:0] w_SrcA;
   logic [XLEN-1:0] w_SrcBRaw;
   logic [XLEN-1:0] w_SrcB;
   logic [XLEN-1:0] w_AluResult;
   logic [XLEN-1:0] w_MulResult;
   logic [XLEN-1:0] w_DivResult;
   logic [XLEN-1:0] w_JalrSum;
   logic            w_DivStall;
   logic            w_BranchCond;

   always_comb begin
      case (i_ForwardA_E)
         2'b01:   w_SrcA = i_ResultW;
         2'b10:   w_SrcA = o_ALU_ResultM;
         default: w_SrcA = i_RD1_E;
      endcase
   end

   always_comb begin
      case (i_ForwardB_E)
         2'b01:   w_SrcBRaw = i_ResultW;
         2'b10:   w_SrcBRaw = o_ALU_ResultM;
         default: w_SrcBRaw = i_RD2_E;
      endcase
   end

   assign w_SrcB = i_ALUSrcE ? i_Imm_Ext_E : w_SrcBRaw;

   // Ops 12-15 present the divider output; it is only captured in the DONE cycle.
   always_comb begin
      w_AluResult = '0;
      case (i_ALUControlE)
         4'd0:    w_AluResult = w_SrcA + w_SrcB;
         4'd1:    w_AluResult = w_SrcA - w_SrcB;
         4'd2:    w_AluResult = w_SrcA & w_SrcB;
         4'd3:    w_AluResult = w_SrcA | w_SrcB;
         4'd4:    w_AluResult = w_SrcA ^ w_SrcB;
         4'd5:    w_AluResult = {{(XLEN-1){1'b0}}, $signed(w_SrcA) < $signed(w_SrcB)};
         4'd6:    w_AluResult = {{(XLEN-1){1'b0}}, w_SrcA < w_SrcB};
         4'd7:    w_AluResult = w_SrcA << w_SrcB[SHW-1:0];
         4'd8:    w_AluResult = w_SrcA >> w_SrcB[SHW-1:0];
         4'd9:    w_AluResult = $signed(w_SrcA) >>> w_SrcB[SHW-1:0];
         4'd10:   w_AluResult = w_MulResult;
         4'd11:   w_AluResult = '0;
         default: w_AluResult = w_DivResult;
      endcase
   end

   // Branch comparisons always use the register operand, never the immediate.
   always_comb begin
      w_BranchCond = 1'b0;
      case (i_BranchOpE)
         3'b000:  w_BranchCond = (w_SrcA == w_SrcBRaw);
         3'b001:  w_BranchCond = (w_SrcA != w_SrcBRaw);
         3'b100:  w_BranchCond = ($signed(w_SrcA) < $signed(w_SrcBRaw));
         3'b101:  w_BranchCond = ($signed(w_SrcA) >= $signed(w_SrcBRaw));
         3'b110:  w_BranchCond = (w_SrcA < w_SrcBRaw);
         3'b111:  w_BranchCond = (w_SrcA >= w_SrcBRaw);
         default: w_BranchCond = 1'b0;
      endcase
   end

   assign w_JalrSum   = w_SrcA + i_Imm_Ext_E;
   assign o_PCSrcE    = i_JumpE | (i_BranchE & w_BranchCond);
   assign o_PCTargetE = i_JalrE ? {w_JalrSum[XLEN-1:1], 1'b0} : (i_PCE + i_Imm_Ext_E);

   generate
      if (MULDIV_EN != 0) begin : g_muldiv
         localparam int CW = $clog2(XLEN);

         divState_t         r_State;
         divState_t         w_NextState;
         logic [CW-1:0]     r_Cnt;
         logic [XLEN-1:0]   r_Quot;
         logic [XLEN-1:0]   r_Rem;
         logic [XLEN-1:0]   r_Divisor;
         logic              r_NegQ;
         logic              r_NegR;
         logic              r_IsRem;
         logic              r_Short;
         logic [XLEN-1:0]   r_ShortRes;
         logic              w_IsDivOp;
         logic              w_Unsigned;
         logic              w_OpRem;
         logic              w_SignA;
         logic              w_SignB;
         logic [XLEN-1:0]   w_AbsA;
         logic [XLEN-1:0]   w_AbsB;
         logic              w_DivZero;
         logic              w_Overflow;
         logic              w_Issue;
         logic [XLEN:0]     w_RemShift;
         logic [XLEN:0]     w_Diff;

         assign w_MulResult = w_SrcA * w_SrcB;

         assign w_IsDivOp  = (i_ALUControlE[3:2] == 2'b11);
         assign w_Unsigned = i_ALUControlE[0];
         assign w_OpRem    = i_ALUControlE[1];
         assign w_SignA    = ~w_Unsigned & w_SrcA[XLEN-1];
         assign w_SignB    = ~w_Unsigned & w_SrcB[XLEN-1];
         assign w_AbsA     = w_SignA ? -w_SrcA : w_SrcA;
         assign w_AbsB     = w_SignB ? -w_SrcB : w_SrcB;
         assign w_DivZero  = (w_SrcB == '0);
         assign w_Overflow = ~w_Unsigned & (w_SrcA == MIN_VAL) & (w_SrcB == '1);
         assign w_Issue    = (r_State == DIV_IDLE) & w_IsDivOp & ~i_FlushE;

         assign w_RemShift = {r_Rem, r_Quot[XLEN-1]};
         assign w_Diff     = w_RemShift - {1'b0, r_Divisor};

         always_comb begin
            w_NextState = r_State;
            w_DivStall  = 1'b0;
            case (r_State)
               DIV_IDLE: begin
                  if (w_Issue) begin
                     w_DivStall  = 1'b1;
                     w_NextState = (w_DivZero | w_Overflow) ? DIV_DONE : DIV_RUN;
                  end
               end
               DIV_RUN: begin
                  if (i_FlushE) begin
                     w_NextState = DIV_IDLE;
                  end else begin
                     w_DivStall = 1'b1;
                     if (r_Cnt == '0) begin
                        w_NextState = DIV_DONE;
                     end
                  end
               end
               DIV_DONE: w_NextState = DIV_IDLE;
               default:  w_NextState = DIV_IDLE;
            endcase
         end

         // Operands are captured at issue so forwarding paths may change while the divide runs.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_State    <= DIV_IDLE;
               r_Cnt      <= '0;
               r_Quot     <= '0;
               r_Rem      <= '0;
               r_Divisor  <= '0;
               r_NegQ     <= 1'b0;
               r_NegR     <= 1'b0;
               r_IsRem    <= 1'b0;
               r_Short    <= 1'b0;
               r_ShortRes <= '0;
            end else begin
               r_State <= w_NextState;
               if (w_Issue) begin
                  r_Cnt     <= CW'(XLEN - 1);
                  r_Quot    <= w_AbsA;
                  r_Rem     <= '0;
                  r_Divisor <= w_AbsB;
                  r_NegQ    <= w_SignA ^ w_SignB;
                  r_NegR    <= w_SignA;
                  r_IsRem   <= w_OpRem;
                  r_Short   <= w_DivZero | w_Overflow;
                  if (w_DivZero) begin
                     r_ShortRes <= w_OpRem ? w_SrcA : '1;
                  end else begin
                     r_ShortRes <= w_OpRem ? '0 : MIN_VAL;
                  end
               end else if (r_State == DIV_RUN) begin
                  r_Cnt  <= r_Cnt - 1'b1;
                  r_Quot <= {r_Quot[XLEN-2:0], ~w_Diff[XLEN]};
                  r_Rem  <= w_Diff[XLEN] ? w_RemShift[XLEN-1:0] : w_Diff[XLEN-1:0];
               end
            end
         end

         always_comb begin
            if (r_Short) begin
               w_DivResult = r_ShortRes;
            end else if (r_IsRem) begin
               w_DivResult = r_NegR ? -r_Rem : r_Rem;
            end else begin
               w_DivResult = r_NegQ ? -r_Quot : r_Quot;
            end
         end
      end else begin : g_nomuldiv
         assign w_MulResult = '0;
         assign w_DivResult = '0;
         assign w_DivStall  = 1'b0;
      end
   endgenerate

   assign o_StallE = w_DivStall & rst;

   // Flush and divider stall both insert a bubble; data registers hold their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_RegWriteM   <= 1'b0;
         o_MemWriteM   <= 1'b0;
         o_ResultSrcM  <= 1'b0;
         o_RD_M        <= '0;
         o_PCPlus4M    <= '0;
         o_WriteDataM  <= '0;
         o_ALU_ResultM <= '0;
      end else if (i_FlushE || w_DivStall) begin
         o_RegWriteM  <= 1'b0;
         o_MemWriteM  <= 1'b0;
         o_ResultSrcM <= 1'b0;
         o_RD_M       <= '0;
      end else begin
         o_RegWriteM   <= i_RegWriteE;
         o_MemWriteM   <= i_MemWriteE;
         o_ResultSrcM  <= i_ResultSrcE;
         o_RD_M        <= i_RD_E;
         o_PCPlus4M    <= i_PCPlus4E;
         o_WriteDataM  <= w_SrcBRaw;
         o_ALU_ResultM <= w_AluResult;
      end
   end

endmodule
